// File: rtl/rvfi_chk_pkg.sv
// Shared types and constants for the RVFI register-file consistency checker.
package rvfi_chk_pkg;

  localparam int unsigned ORDER_W   = 64;
  localparam int unsigned REGADDR_W = 5;

  typedef enum logic [2:0] {
    ErrNone  = 3'd0,
    ErrRs1   = 3'd1,
    ErrRs2   = 3'd2,
    ErrRd0   = 3'd3,
    ErrOrder = 3'd4
  } err_kind_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/rvfi_reg_shadow.sv
// Shadow integer register file with known bits, NRET ordered write ports and
// 2*NRET read ports (rs1 on port 2k, rs2 on port 2k+1) bypassing from lower channels.
module rvfi_reg_shadow import rvfi_chk_pkg::*; #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NRET      = 1,
  parameter int unsigned NREGS     = 32,
  parameter bit          ZERO_INIT = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NRET-1:0]               wr_en_i,
  input  logic [REGADDR_W*NRET-1:0]     wr_addr_i,
  input  logic [XLEN*NRET-1:0]          wr_data_i,
  input  logic [REGADDR_W*2*NRET-1:0]   rd_addr_i,
  output logic [XLEN*2*NRET-1:0]        rd_data_o,
  output logic [2*NRET-1:0]             rd_known_o
);

  localparam int unsigned IdxW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int unsigned AddrW1 = REGADDR_W + 1;
  localparam logic [REGADDR_W:0] NregsW = AddrW1'(NREGS);
  localparam logic [NREGS-1:0] KnownRst = ZERO_INIT ? {NREGS{1'b1}} : NREGS'(1);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] known_q, known_d;
  logic [NRET-1:0]  we;

  function automatic logic in_range(input logic [REGADDR_W-1:0] a);
    in_range = ({1'b0, a} < NregsW);
  endfunction

  function automatic logic [IdxW-1:0] to_idx(input logic [REGADDR_W-1:0] a);
    to_idx = a[IdxW-1:0];
  endfunction

  // x0 and out-of-range addresses never write, so x0 stays 0 and known.
  always_comb begin
    we = '0;
    for (int k = 0; k < NRET; k++) begin
      we[k] = wr_en_i[k] && (wr_addr_i[k*REGADDR_W +: REGADDR_W] != '0) &&
              in_range(wr_addr_i[k*REGADDR_W +: REGADDR_W]);
    end
  end

  // Ascending channel order: the highest colliding channel wins.
  always_comb begin
    regs_d  = regs_q;
    known_d = known_q;
    for (int k = 0; k < NRET; k++) begin
      if (we[k]) begin
        regs_d[to_idx(wr_addr_i[k*REGADDR_W +: REGADDR_W])]  = wr_data_i[k*XLEN +: XLEN];
        known_d[to_idx(wr_addr_i[k*REGADDR_W +: REGADDR_W])] = 1'b1;
      end
    end
  end

  always_comb begin
    rd_data_o  = '0;
    rd_known_o = '0;
    for (int p = 0; p < 2 * NRET; p++) begin
      if (in_range(rd_addr_i[p*REGADDR_W +: REGADDR_W])) begin
        rd_data_o[p*XLEN +: XLEN] = regs_q[to_idx(rd_addr_i[p*REGADDR_W +: REGADDR_W])];
        rd_known_o[p]             = known_q[to_idx(rd_addr_i[p*REGADDR_W +: REGADDR_W])];
      end
      for (int j = 0; j < p / 2; j++) begin
        if (we[j] && (wr_addr_i[j*REGADDR_W +: REGADDR_W] ==
                      rd_addr_i[p*REGADDR_W +: REGADDR_W])) begin
          rd_data_o[p*XLEN +: XLEN] = wr_data_i[j*XLEN +: XLEN];
          rd_known_o[p]             = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      known_q <= KnownRst;
    end else begin
      regs_q  <= regs_d;
      known_q <= known_d;
    end
  end

endmodule

// File: rtl/rvfi_reg_check_multi.sv
// Multi-channel RVFI register-file consistency checker: compares rs1/rs2 reads
// against a shadow register file, checks x0 writes and retire order, captures the first error.
module rvfi_reg_check_multi import rvfi_chk_pkg::*; #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NRET      = 1,
  parameter int unsigned NREGS     = 32,
  parameter bit          ZERO_INIT = 1'b1
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      check_i,
  input  logic [NRET-1:0]           rvfi_valid_i,
  input  logic [ORDER_W*NRET-1:0]   rvfi_order_i,
  input  logic [REGADDR_W*NRET-1:0] rvfi_rs1_addr_i,
  input  logic [REGADDR_W*NRET-1:0] rvfi_rs2_addr_i,
  input  logic [REGADDR_W*NRET-1:0] rvfi_rd_addr_i,
  input  logic [XLEN*NRET-1:0]      rvfi_rs1_rdata_i,
  input  logic [XLEN*NRET-1:0]      rvfi_rs2_rdata_i,
  input  logic [XLEN*NRET-1:0]      rvfi_rd_wdata_i,
  output logic                      error_o,
  output logic                      err_valid_o,
  output logic [2:0]                err_kind_o,
  output logic [1:0]                err_chan_o,
  output logic [ORDER_W-1:0]        err_order_o,
  output logic [31:0]               check_count_o
);

  logic [REGADDR_W*2*NRET-1:0] sh_raddr;
  logic [XLEN*2*NRET-1:0]      sh_rdata;
  logic [2*NRET-1:0]           sh_known;

  logic [NRET-1:0] e_rs1, e_rs2, e_rd0, e_ord;
  logic [NRET:0]   vprev;
  logic            any_err;
  err_kind_t       sel_kind;
  logic [1:0]      sel_chan;
  logic [ORDER_W-1:0] sel_order;
  logic [2:0]      n_ret;
  logic [32:0]     cnt_sum;

  logic               error_q, error_d;
  logic               err_valid_q, err_valid_d;
  err_kind_t          err_kind_q, err_kind_d;
  logic [1:0]         err_chan_q, err_chan_d;
  logic [ORDER_W-1:0] err_order_q, err_order_d;
  logic [31:0]        count_q, count_d;
  logic [ORDER_W-1:0] exp_order_q, exp_order_d;

  always_comb begin
    sh_raddr = '0;
    for (int k = 0; k < NRET; k++) begin
      sh_raddr[(2*k)*REGADDR_W +: REGADDR_W]   = rvfi_rs1_addr_i[k*REGADDR_W +: REGADDR_W];
      sh_raddr[(2*k+1)*REGADDR_W +: REGADDR_W] = rvfi_rs2_addr_i[k*REGADDR_W +: REGADDR_W];
    end
  end

  rvfi_reg_shadow #(
    .XLEN      (XLEN),
    .NRET      (NRET),
    .NREGS     (NREGS),
    .ZERO_INIT (ZERO_INIT)
  ) u_shadow (
    .clk_i      (clock_i),
    .rst_i      (reset_i),
    .wr_en_i    (rvfi_valid_i),
    .wr_addr_i  (rvfi_rd_addr_i),
    .wr_data_i  (rvfi_rd_wdata_i),
    .rd_addr_i  (sh_raddr),
    .rd_data_o  (sh_rdata),
    .rd_known_o (sh_known)
  );

  // vprev[k] is valid[k-1]; channel 0 has an implicit valid predecessor.
  assign vprev = {rvfi_valid_i, 1'b1};

  always_comb begin
    e_rs1 = '0;
    e_rs2 = '0;
    e_rd0 = '0;
    e_ord = '0;
    for (int k = 0; k < NRET; k++) begin
      e_rs1[k] = rvfi_valid_i[k] && sh_known[2*k] &&
                 (sh_rdata[(2*k)*XLEN +: XLEN] != rvfi_rs1_rdata_i[k*XLEN +: XLEN]);
      e_rs2[k] = rvfi_valid_i[k] && sh_known[2*k+1] &&
                 (sh_rdata[(2*k+1)*XLEN +: XLEN] != rvfi_rs2_rdata_i[k*XLEN +: XLEN]);
      e_rd0[k] = rvfi_valid_i[k] && (rvfi_rd_addr_i[k*REGADDR_W +: REGADDR_W] == '0) &&
                 (rvfi_rd_wdata_i[k*XLEN +: XLEN] != '0);
      e_ord[k] = rvfi_valid_i[k] && (!vprev[k] ||
                 (rvfi_order_i[k*ORDER_W +: ORDER_W] != exp_order_q + ORDER_W'(k)));
    end
  end

  // Descending scan so the lowest erroring channel is the one left selected.
  always_comb begin
    any_err   = 1'b0;
    sel_kind  = ErrNone;
    sel_chan  = '0;
    sel_order = '0;
    for (int k = NRET - 1; k >= 0; k--) begin
      if (e_rs1[k] || e_rs2[k] || e_rd0[k] || e_ord[k]) begin
        any_err   = 1'b1;
        sel_chan  = 2'(k);
        sel_order = rvfi_order_i[k*ORDER_W +: ORDER_W];
        if (e_rs1[k])      sel_kind = ErrRs1;
        else if (e_rs2[k]) sel_kind = ErrRs2;
        else if (e_rd0[k]) sel_kind = ErrRd0;
        else               sel_kind = ErrOrder;
      end
    end
  end

  assign n_ret   = popcount4(4'(rvfi_valid_i));
  assign cnt_sum = {1'b0, count_q} + 33'(n_ret);

  always_comb begin
    err_valid_d = 1'b0;
    error_d     = error_q;
    err_kind_d  = err_kind_q;
    err_chan_d  = err_chan_q;
    err_order_d = err_order_q;
    count_d     = count_q;
    exp_order_d = exp_order_q + ORDER_W'(n_ret);
    if (check_i) begin
      err_valid_d = any_err;
      error_d     = error_q | any_err;
      count_d     = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
      if (any_err && !error_q) begin
        err_kind_d  = sel_kind;
        err_chan_d  = sel_chan;
        err_order_d = sel_order;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      error_q     <= 1'b0;
      err_valid_q <= 1'b0;
      err_kind_q  <= ErrNone;
      err_chan_q  <= '0;
      err_order_q <= '0;
      count_q     <= '0;
      exp_order_q <= '0;
    end else begin
      error_q     <= error_d;
      err_valid_q <= err_valid_d;
      err_kind_q  <= err_kind_d;
      err_chan_q  <= err_chan_d;
      err_order_q <= err_order_d;
      count_q     <= count_d;
      exp_order_q <= exp_order_d;
    end
  end

  assign error_o       = error_q;
  assign err_valid_o   = err_valid_q;
  assign err_kind_o    = err_kind_q;
  assign err_chan_o    = err_chan_q;
  assign err_order_o   = err_order_q;
  assign check_count_o = count_q;

endmodule

// File: tb/tb_rvfi_reg_check_multi.sv
// Scoreboard bench: dut_a is NRET=2/ZERO_INIT=1, dut_b is NRET=1/NREGS=16/ZERO_INIT=0.
module tb_rvfi_reg_check_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, chk;

  logic [1:0]   a_valid;
  logic [127:0] a_order;
  logic [9:0]   a_rs1a, a_rs2a, a_rda;
  logic [63:0]  a_rs1d, a_rs2d, a_rdd;
  logic         a_error, a_ev;
  logic [2:0]   a_kind;
  logic [1:0]   a_chan;
  logic [63:0]  a_eord;
  logic [31:0]  a_cnt;

  logic [0:0]   b_valid;
  logic [63:0]  b_order;
  logic [4:0]   b_rs1a, b_rs2a, b_rda;
  logic [31:0]  b_rs1d, b_rs2d, b_rdd;
  logic         b_error, b_ev;
  logic [2:0]   b_kind;
  logic [1:0]   b_chan;
  logic [63:0]  b_eord;
  logic [31:0]  b_cnt;

  rvfi_reg_check_multi #(
    .XLEN (32), .NRET (2), .NREGS (32), .ZERO_INIT (1'b1)
  ) dut_a (
    .clock_i (clk), .reset_i (rst), .check_i (chk),
    .rvfi_valid_i (a_valid), .rvfi_order_i (a_order),
    .rvfi_rs1_addr_i (a_rs1a), .rvfi_rs2_addr_i (a_rs2a), .rvfi_rd_addr_i (a_rda),
    .rvfi_rs1_rdata_i (a_rs1d), .rvfi_rs2_rdata_i (a_rs2d), .rvfi_rd_wdata_i (a_rdd),
    .error_o (a_error), .err_valid_o (a_ev), .err_kind_o (a_kind), .err_chan_o (a_chan),
    .err_order_o (a_eord), .check_count_o (a_cnt)
  );

  rvfi_reg_check_multi #(
    .XLEN (32), .NRET (1), .NREGS (16), .ZERO_INIT (1'b0)
  ) dut_b (
    .clock_i (clk), .reset_i (rst), .check_i (chk),
    .rvfi_valid_i (b_valid), .rvfi_order_i (b_order),
    .rvfi_rs1_addr_i (b_rs1a), .rvfi_rs2_addr_i (b_rs2a), .rvfi_rd_addr_i (b_rda),
    .rvfi_rs1_rdata_i (b_rs1d), .rvfi_rs2_rdata_i (b_rs2d), .rvfi_rd_wdata_i (b_rdd),
    .error_o (b_error), .err_valid_o (b_ev), .err_kind_o (b_kind), .err_chan_o (b_chan),
    .err_order_o (b_eord), .check_count_o (b_cnt)
  );

  typedef struct {
    bit          sel;
    logic        ev;
    logic        err;
    logic [2:0]  kind;
    logic [1:0]  chan;
    logic [63:0] ord;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic idle();
    a_valid = '0; a_order = '0; a_rs1a = '0; a_rs2a = '0; a_rda = '0;
    a_rs1d  = '0; a_rs2d  = '0; a_rdd  = '0;
    b_valid = '0; b_order = '0; b_rs1a = '0; b_rs2a = '0; b_rda = '0;
    b_rs1d  = '0; b_rs2d  = '0; b_rdd  = '0;
  endtask

  task automatic set_a(input int k, input logic [63:0] ord,
                       input logic [4:0] rs1a, input logic [31:0] rs1d,
                       input logic [4:0] rs2a, input logic [31:0] rs2d,
                       input logic [4:0] rda, input logic [31:0] rdd);
    a_valid[k]          = 1'b1;
    a_order[k*64 +: 64] = ord;
    a_rs1a[k*5 +: 5]    = rs1a;
    a_rs1d[k*32 +: 32]  = rs1d;
    a_rs2a[k*5 +: 5]    = rs2a;
    a_rs2d[k*32 +: 32]  = rs2d;
    a_rda[k*5 +: 5]     = rda;
    a_rdd[k*32 +: 32]   = rdd;
  endtask

  task automatic set_b(input logic [63:0] ord,
                       input logic [4:0] rs1a, input logic [31:0] rs1d,
                       input logic [4:0] rda, input logic [31:0] rdd);
    b_valid = 1'b1; b_order = ord;
    b_rs1a  = rs1a; b_rs1d  = rs1d;
    b_rs2a  = '0;   b_rs2d  = '0;
    b_rda   = rda;  b_rdd   = rdd;
  endtask

  // Push the expected outputs for the current stimulus, clock it, then compare.
  task automatic step(input bit sel, input logic ev, input logic err, input logic [2:0] kind,
                      input logic [1:0] chan, input logic [63:0] ord, input logic [31:0] cnt);
    exp_t e;
    e.sel = sel; e.ev = ev; e.err = err; e.kind = kind; e.chan = chan; e.ord = ord; e.cnt = cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (!e.sel) begin
      check_val("a.err_valid", 64'(a_ev), 64'(e.ev));
      check_val("a.error", 64'(a_error), 64'(e.err));
      check_val("a.err_kind", 64'(a_kind), 64'(e.kind));
      check_val("a.err_chan", 64'(a_chan), 64'(e.chan));
      check_val("a.err_order", a_eord, e.ord);
      check_val("a.check_count", 64'(a_cnt), 64'(e.cnt));
    end else begin
      check_val("b.err_valid", 64'(b_ev), 64'(e.ev));
      check_val("b.error", 64'(b_error), 64'(e.err));
      check_val("b.err_kind", 64'(b_kind), 64'(e.kind));
      check_val("b.err_chan", 64'(b_chan), 64'(e.chan));
      check_val("b.err_order", b_eord, e.ord);
      check_val("b.check_count", 64'(b_cnt), 64'(e.cnt));
    end
    idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 0, 0, 3'd0, 2'd0, 64'd0, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    chk = 1'b1;
    idle();
    step(1'b0, 0, 0, 3'd0, 2'd0, 64'd0, 32'd0);
    step(1'b1, 0, 0, 3'd0, 2'd0, 64'd0, 32'd0);
    rst = 1'b0;

    // Single channel write then read, match and mismatch.
    set_a(0, 0, 0, 0, 0, 0, 5, 32'h1234);
    step(1'b0, 0, 0, 3'd0, 2'd0, 64'd0, 32'd1);
    set_a(0, 1, 5, 32'h1234, 0, 0, 0, 0);
    step(1'b0, 0, 0, 3'd0, 2'd0, 64'd0, 32'd2);
    set_a(0, 2, 5, 32'h1235, 0, 0, 0, 0);
    step(1'b0, 1, 1, 3'd1, 2'd0, 64'd2, 32'd3);
    step(1'b0, 0, 1, 3'd1, 2'd0, 64'd2, 32'd3);

    // Same-cycle bypass, rd collision and held first-error fields.
    do_reset();
    set_a(0, 0, 0, 0, 0, 0, 3, 9);
    set_a(1, 1, 0, 0, 3, 9, 0, 0);
    step(1'b0, 0, 0, 3'd0, 2'd0, 64'd0, 32'd2);
    set_a(0, 2, 0, 0, 0, 0, 3, 9);
    set_a(1, 3, 0, 0, 3, 8, 0, 0);
    step(1'b0, 1, 1, 3'd2, 2'd1, 64'd3, 32'd4);
    set_a(0, 4, 9, 32'hDEAD, 0, 0, 0, 0);
    step(1'b0, 1, 1, 3'd2, 2'd1, 64'd3, 32'd5);
    set_a(0, 5, 0, 0, 0, 0, 4, 1);
    set_a(1, 6, 0, 0, 0, 0, 4, 2);
    step(1'b0, 0, 1, 3'd2, 2'd1, 64'd3, 32'd7);
    set_a(0, 7, 4, 2, 4, 2, 0, 0);
    step(1'b0, 0, 1, 3'd2, 2'd1, 64'd3, 32'd8);

    // Unpacked valid is an order error on the upper channel.
    do_reset();
    set_a(1, 0, 0, 0, 0, 0, 0, 0);
    step(1'b0, 1, 1, 3'd4, 2'd1, 64'd0, 32'd1);
    set_a(0, 1, 0, 0, 0, 0, 0, 0);
    step(1'b0, 0, 1, 3'd4, 2'd1, 64'd0, 32'd2);

    // check=0 suppresses reporting but exp_order still advances; order gap.
    do_reset();
    chk = 1'b0;
    set_a(0, 0, 0, 0, 0, 0, 0, 5);
    step(1'b0, 0, 0, 3'd0, 2'd0, 64'd0, 32'd0);
    chk = 1'b1;
    set_a(0, 1, 0, 0, 0, 0, 0, 0);
    step(1'b0, 0, 0, 3'd0, 2'd0, 64'd0, 32'd1);
    set_a(0, 3, 0, 0, 0, 0, 0, 0);
    step(1'b0, 1, 1, 3'd4, 2'd0, 64'd3, 32'd2);
    set_a(0, 3, 0, 0, 0, 0, 0, 5);
    step(1'b0, 1, 1, 3'd4, 2'd0, 64'd3, 32'd3);
    chk = 1'b0;
    set_a(0, 4, 5, 1, 0, 0, 0, 0);
    step(1'b0, 0, 1, 3'd4, 2'd0, 64'd3, 32'd3);
    chk = 1'b1;

    // RD0 on ch0 beats RS1 on ch1; shadow re-zeroed by reset.
    do_reset();
    set_a(0, 0, 0, 0, 0, 0, 0, 5);
    set_a(1, 1, 5, 7, 0, 0, 0, 0);
    step(1'b0, 1, 1, 3'd3, 2'd0, 64'd0, 32'd2);
    set_a(0, 2, 5, 0, 0, 0, 0, 0);
    step(1'b0, 0, 1, 3'd3, 2'd0, 64'd0, 32'd3);

    // Within-channel priority: RS1 over RS2/RD0/ORDER, then RS2 over RD0/ORDER.
    do_reset();
    set_a(0, 7, 5, 1, 6, 1, 0, 5);
    step(1'b0, 1, 1, 3'd1, 2'd0, 64'd7, 32'd1);
    do_reset();
    set_a(0, 7, 0, 0, 6, 1, 0, 5);
    step(1'b0, 1, 1, 3'd2, 2'd0, 64'd7, 32'd1);

    // ZERO_INIT=0, NREGS=16 instance.
    do_reset();
    set_b(0, 7, 32'hDEAD, 0, 0);
    step(1'b1, 0, 0, 3'd0, 2'd0, 64'd0, 32'd1);
    set_b(1, 20, 9, 20, 1);
    step(1'b1, 0, 0, 3'd0, 2'd0, 64'd0, 32'd2);
    set_b(2, 4, 32'hAA, 7, 3);
    step(1'b1, 0, 0, 3'd0, 2'd0, 64'd0, 32'd3);
    set_b(3, 7, 4, 0, 0);
    step(1'b1, 1, 1, 3'd1, 2'd0, 64'd3, 32'd4);
    set_b(4, 0, 1, 0, 0);
    step(1'b1, 1, 1, 3'd1, 2'd0, 64'd3, 32'd5);
    rst = 1'b1;
    step(1'b1, 0, 0, 3'd0, 2'd0, 64'd0, 32'd0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rvfi_reg_check_multi.md
# rvfi_reg_check_multi

Multi-channel register-file consistency checker on the RVFI trace port. It keeps a shadow copy of the architectural integer register file from retired `rd` writes. Every `rs1`/`rs2` read value is compared against the shadow, and instruction order across NRET retire channels is checked. It generalises the single-channel reg check (fixed XLEN, one retire slot) to configurable XLEN, NRET, NREGS and zero-init mode, and adds order checking, x0-write checking and first-error capture for formal and simulation harnesses.

## Interface
- XLEN, 32, data width of rdata/wdata
- NRET, 1, retire channels per cycle (1..4)
- NREGS, 32, architectural registers (32 = RV32I, 16 = RV32E)
- ZERO_INIT, 1, 1: shadow starts all-zero and known; 0: each register is unknown until its first write
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- check  in  1  enables error reporting; shadow tracking continues while low
- rvfi_valid  in  NRET  per-channel retire strobe
- rvfi_order  in  64*NRET  instruction index
- rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr  in  5*NRET  register addresses
- rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata  in  XLEN*NRET  register values
- error  out  1  sticky, set by the first reported error
- err_valid  out  1  one-cycle pulse per erroring retire cycle
- err_kind  out  3  kind of the first error: 0 none, 1 RS1, 2 RS2, 3 RD0, 4 ORDER
- err_chan  out  2  channel of the first error
- err_order  out  64  rvfi_order of the first error
- check_count  out  32  saturating count of checked retirements

## Operation
- Shadow: NREGS x XLEN plus a known bit per register. x0 always reads 0 and is always known.
- Known bits at reset: ZERO_INIT=1 sets all known with value 0. ZERO_INIT=0 clears all, and a write marks the register known.
- Channels are processed in index order within a cycle. Channel k sees `rd` writes from valid channels j<k in the same cycle (bypass). On a same-cycle `rd` collision, the highest channel's value wins in the shadow.
- RS1 error: rs1_addr<NREGS, the register is known, and rs1_rdata != shadow value. RS2 error: the same test on rs2.
- RD0 error: rd_addr==0 and rd_wdata != 0.
- ORDER error, either condition: valid[k]=1 while valid[k-1]=0 (channels must be packed lowest-first); or rvfi_order[k] != exp_order + k.
- exp_order: 0 after reset; advances by popcount(valid) every cycle.
- Addresses >= NREGS are ignored for both check and write.
- Priority on multiple errors: lowest channel first, then RS1 > RS2 > RD0 > ORDER within a channel.
- When check=0: no err_valid, error, first-error capture or count update. Shadow and exp_order still update.
- First-error fields latch only while error=0 and hold until reset.
- check_count saturates at 2^32-1.

## Timing
- All outputs are registered and 0 after reset.
- Latency: inputs at edge N give err_valid/error/err_* at N+1. Shadow writes from edge N are visible to reads at N+1; same-cycle visibility is via the bypass.
- No backpressure: every input cycle is consumed.
- Reset asserted mid-run discards all shadow contents, known bits, exp_order, count and captured error on the next edge.

## Structure
- Package `rvfi_chk_pkg` holds the `err_kind_t` enum (NONE, RS1, RS2, RD0, ORDER) and the `ORDER_W=64` and `REGADDR_W=5` constants.
- Sub-module `rvfi_reg_shadow` holds the shadow array, known bits, NRET write ports with ordered collision resolution, and 2*NRET combinational read ports with intra-cycle bypass.
- The top level holds the order tracker, the comparators, the priority encoder, first-error capture and the counter.

## Test plan
- ZERO_INIT=1, NRET=1: retire x5<=0x1234, then read rs1=x5 with rdata 0x1234 -> no error. Read x5 with rdata 0x1235 -> err_valid next cycle, err_kind=1, err_chan=0.
- ZERO_INIT=0: read x7 (never written) with rdata 0xDEAD -> no error. Write x7<=3, then read x7 with rdata 4 -> RS1 error.
- NRET=2, same cycle: ch0 writes x3<=9 and ch1 reads rs2=x3 with rdata 9 -> no error. Same stimulus with ch1 rdata 8 -> err_kind=2, err_chan=1.
- Order: valid=2'b10 -> ORDER error on ch1. Orders 0,1 then 3 -> ORDER error with err_order=3. check_count stops incrementing only if check=0.
- rd_addr=0 with rd_wdata=5 -> RD0 error. A second, later error leaves the first-error fields unchanged.
- Reset asserted after an error -> all outputs 0 next cycle, exp_order=0, and the shadow is re-initialised per ZERO_INIT.
